spi_ram_burst: RTL and testbench

//  Parametrised single-port RAM behind the SPI slave. Decodes {cmd[1:0], payload} words from
//  the SPI shift logic. Keeps independent write and read address pointers with optional

---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spr_mem_array.sv | 29 ++
 rtl/spi_ram_burst.sv | 120 ++++++++++++
 tb/tb_spi_ram_burst.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes and tx handshake state encoding for the SPI-attached burst RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/spr_mem_array.sv
// MEM_DEPTH x DATA_W single-port array, registered read, contents never reset.
module spr_mem_array #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = {1'b0, addr} < (ADDR_W + 1)'(MEM_DEPTH);
  assign idx      = addr[IDX_W-1:0];

  // Read-first: a same-cycle write is visible on the following access.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
    rdata <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, write/read pointers and tx valid/ready stage in front of the burst RAM.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam int unsigned PTR_EXT = ADDR_W + 1;

  tx_state_e         tx_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              fresh_q;
  logic              oor_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] pay_addr;
  logic              is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;
  logic              wr_in_range, rd_in_range;
  logic              rd_accept, rd_overrun, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    if ({1'b0, p} == PTR_EXT'(MEM_DEPTH - 1)) return '0;
    return p + ADDR_W'(1);
  endfunction

  assign cmd      = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign pay_addr = din[ADDR_W-1:0];

  assign is_wr_addr = rx_valid && (cmd == CMD_WR_ADDR);
  assign is_wr_data = rx_valid && (cmd == CMD_WR_DATA);
  assign is_rd_addr = rx_valid && (cmd == CMD_RD_ADDR);
  assign is_rd_data = rx_valid && (cmd == CMD_RD_DATA);

  assign wr_in_range = {1'b0, wr_ptr} < PTR_EXT'(MEM_DEPTH);
  assign rd_in_range = {1'b0, rd_ptr} < PTR_EXT'(MEM_DEPTH);

  // A read is dropped only when an unaccepted word is still being presented.
  assign rd_overrun = is_rd_data && (tx_state == TX_FULL) && !tx_ready;
  assign rd_accept  = is_rd_data && !rd_overrun;
  assign mem_we     = rst_n && is_wr_data && wr_in_range;
  assign mem_addr   = is_wr_data ? wr_ptr : rd_ptr;

  spr_mem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(mem_rdata)
  );

  // The array's read register carries the fresh word; hold_q keeps it afterwards.
  assign dout = fresh_q ? (oor_q ? '0 : mem_rdata) : hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_EMPTY;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fresh_q  <= 1'b0;
      oor_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      err <= (is_wr_data && !wr_in_range) || rd_overrun || (rd_accept && !rd_in_range);

      if (is_wr_addr)                 wr_ptr <= pay_addr;
      else if (is_wr_data && AUTO_INC) wr_ptr <= ptr_next(wr_ptr);

      if (is_rd_addr)                 rd_ptr <= pay_addr;
      else if (rd_accept && AUTO_INC) rd_ptr <= ptr_next(rd_ptr);

      if (fresh_q) hold_q <= dout;
      fresh_q <= rd_accept;
      if (rd_accept) oor_q <= !rd_in_range;

      case (tx_state)
        TX_EMPTY: begin
          if (rd_accept) begin
            tx_state <= TX_FULL;
            tx_valid <= 1'b1;
          end
        end
        TX_FULL: begin
          if (!rd_accept && tx_ready) begin
            tx_state <= TX_EMPTY;
            tx_valid <= 1'b0;
          end
        end
        default: begin
          tx_state <= TX_EMPTY;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench: two RAM configurations share one randomized command stream and are checked
// against a behavioural per-cycle model.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic       tx_ready;
  logic [7:0] dout0, dout1;
  logic       tx_valid0, tx_valid1, err0, err1;

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_ready(tx_ready),
    .dout(dout0), .tx_valid(tx_valid0), .err(err0)
  );

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_ready(tx_ready),
    .dout(dout1), .tx_valid(tx_valid1), .err(err1)
  );

  typedef struct {
    logic       v;
    logic       e;
    logic [7:0] d;
    bit         chk_d;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, one slot per configuration.
  int mem_m [2][256];
  int wp [2];
  int rp [2];
  bit full [2];
  int hd [2];
  int depth [2] = '{256, 200};
  bit inc [2]   = '{1'b1, 1'b0};

  function automatic int adv(input int i, input int p);
    return (p == depth[i] - 1) ? 0 : (p + 1) % 256;
  endfunction

  task automatic step(input int i, input bit r, input bit rv, input bit [1:0] c,
                      input int pay, input bit rdy, output exp_t x);
    bit was_full;
    bit took;
    was_full = full[i];
    took     = 1'b0;
    x.e      = 1'b0;
    if (r) begin
      wp[i] = 0; rp[i] = 0; full[i] = 1'b0; hd[i] = 0;
      x.v = 1'b0; x.d = 8'h00; x.chk_d = 1'b1;
      return;
    end
    if (rv) begin
      case (c)
        2'b00: wp[i] = pay;
        2'b01: begin
          if (wp[i] < depth[i]) mem_m[i][wp[i]] = pay;
          else x.e = 1'b1;
          if (inc[i]) wp[i] = adv(i, wp[i]);
        end
        2'b10: rp[i] = pay;
        default: begin
          if (was_full && !rdy) x.e = 1'b1;
          else begin
            took = 1'b1;
            if (rp[i] < depth[i]) hd[i] = mem_m[i][rp[i]];
            else begin hd[i] = 0; x.e = 1'b1; end
            if (inc[i]) rp[i] = adv(i, rp[i]);
          end
        end
      endcase
    end
    if (took) full[i] = 1'b1;
    else if (was_full && rdy) full[i] = 1'b0;
    x.v     = full[i];
    x.d     = 8'(hd[i]);
    x.chk_d = full[i];
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  // Drive one cycle of inputs and queue what each DUT must show after the coming edge.
  task automatic cyc(input bit r, input bit rv, input bit [1:0] c, input int pay, input bit rdy);
    exp_t x;
    rst_n    = !r;
    rx_valid = rv;
    din      = {c, 8'(pay)};
    tx_ready = rdy;
    step(0, r, rv, c, pay, rdy, x); q0.push_back(x);
    step(1, r, rv, c, pay, rdy, x); q1.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("dut0 tx_valid", int'(tx_valid0), int'(x.v));
      chk("dut0 err", int'(err0), int'(x.e));
      if (x.chk_d) chk("dut0 dout", int'(dout0), int'(x.d));
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("dut1 tx_valid", int'(tx_valid1), int'(x.v));
      chk("dut1 err", int'(err1), int'(x.e));
      if (x.chk_d) chk("dut1 dout", int'(dout1), int'(x.d));
    end
  end

  initial begin
    cyc(1, 0, 2'b00, 0, 0);
    cyc(1, 0, 2'b00, 0, 0);
    // Fill every address so later reads are fully defined.
    for (int a = 0; a < 256; a++) begin
      cyc(0, 1, 2'b00, a, 1);
      cyc(0, 1, 2'b01, int'($urandom_range(255)), 1);
    end
    // Reset held with write commands toggling: nothing may be written.
    for (int k = 0; k < 3; k++) cyc(1, (k % 2) == 0, 2'b01, int'($urandom_range(255)), 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    // Burst write then read.
    cyc(0, 1, 2'b00, 'h10, 1);
    cyc(0, 1, 2'b01, 'hA1, 1);
    cyc(0, 1, 2'b01, 'hB2, 1);
    cyc(0, 1, 2'b01, 'hC3, 1);
    cyc(0, 1, 2'b10, 'h10, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    // Pointer wrap at the top of the array.
    cyc(0, 1, 2'b00, 'hFF, 1);
    cyc(0, 1, 2'b01, 'h11, 1);
    cyc(0, 1, 2'b01, 'h22, 1);
    cyc(0, 1, 2'b10, 'hFF, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    // Overrun while the serialiser stalls.
    cyc(0, 1, 2'b10, 'h10, 1);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    // Address 0xC8: in range for dut0, beyond MEM_DEPTH for dut1.
    cyc(0, 1, 2'b00, 'hC8, 1);
    cyc(0, 1, 2'b01, 'h55, 1);
    cyc(0, 1, 2'b10, 'hC8, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    // Repeated reads at one address, then reset while a word is pending.
    cyc(0, 1, 2'b10, 'h05, 1);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(0, 1, 2'b11, 0, 0);
    cyc(0, 1, 2'b11, 0, 1);
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 1);
    // Randomized traffic with occasional reset.
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(149) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
          int'($urandom_range(255)), $urandom_range(2) != 0);
    end
    cyc(0, 0, 2'b00, 0, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
